// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: issues one wide operation to a 4-bit 181-style ALU slice, one nibble per cycle LSB first,
// chaining the slice carry and assembling the wide result, carry and equality flags.
module alu_slice_sequencer #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [3:0]   select_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         equal_o,
    output logic         alu_mode_o,
    output logic [3:0]   alu_select_o,
    output logic [3:0]   alu_a_o,
    output logic [3:0]   alu_b_o,
    output logic         alu_carry_o,
    input  logic [3:0]   alu_f_i,
    input  logic         alu_carry_i,
    input  logic         alu_cmp_i
);
    localparam int CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_mode;
    logic [3:0]     r_sel;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_cin_n;
    logic           r_acc;
    logic [W-5:0]   r_f;
    logic [W-1:0]   r_result;
    logic           r_carry;
    logic           r_equal;
    logic           w_run;
    logic           w_last;
    logic           w_accept;
    logic [W-1:0]   w_fnext;

    always_comb begin
        w_run    = r_state == S_RUN;
        w_last   = r_cnt == CW'(NIBBLES - 1);
        w_accept = start_i && !w_run;
        w_next   = w_accept ? S_RUN : w_run ? (w_last ? S_DONE : S_RUN) : S_IDLE;
        w_fnext  = {alu_f_i, r_f};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Slice nibbles shift in from the top so nibble 0 lands at the bottom after the last cycle;
    // the visible result is copied only at completion so it stays stable between operations.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_sel    <= 4'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin_n  <= 1'b1;
            r_acc    <= 1'b1;
            r_f      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_equal  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_mode  <= mode_i;
            r_sel   <= select_i;
            r_a     <= a_i;
            r_b     <= b_i;
            r_cin_n <= ~carry_i;
            r_acc   <= 1'b1;
        end else if (w_run) begin
            r_cnt   <= r_cnt + CW'(1);
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_cin_n <= alu_carry_i;
            r_acc   <= r_acc & alu_cmp_i;
            r_f     <= w_fnext[W-1:4];
            if (w_last) begin
                r_result <= w_fnext;
                r_carry  <= ~alu_carry_i;
                r_equal  <= r_acc & alu_cmp_i;
            end
        end
    end

    always_comb begin
        busy_o       = w_run;
        done_o       = r_state == S_DONE;
        result_o     = r_result;
        carry_o      = r_carry;
        equal_o      = r_equal;
        alu_mode_o   = w_run ? r_mode : 1'b0;
        alu_select_o = w_run ? r_sel : 4'd0;
        alu_a_o      = w_run ? r_a[3:0] : 4'd0;
        alu_b_o      = w_run ? r_b[3:0] : 4'd0;
        alu_carry_o  = w_run ? r_cin_n : 1'b1;
    end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: directed checks of the sequencer driving a behavioural 181-style slice.
module tb_alu_slice_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [3:0]  select_i = 4'd0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        carry_i = 1'b0;
    logic        busy_o, done_o, carry_o, equal_o;
    logic [15:0] result_o;
    logic        alu_mode_o, alu_carry_o;
    logic [3:0]  alu_select_o, alu_a_o, alu_b_o;
    logic [3:0]  alu_f_i;
    logic        alu_carry_i, alu_cmp_i;
    int          total = 0;
    int          bad = 0;
    int          lat;
    int          dones;
    logic [3:0]  nibc;

    always #5 clk_i = ~clk_i;

    alu_slice_sequencer #(.NIBBLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .select_i(select_i), .a_i(a_i), .b_i(b_i), .carry_i(carry_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .carry_o(carry_o),
        .equal_o(equal_o), .alu_mode_o(alu_mode_o), .alu_select_o(alu_select_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_carry_o(alu_carry_o),
        .alu_f_i(alu_f_i), .alu_carry_i(alu_carry_i), .alu_cmp_i(alu_cmp_i)
    );

    // Slice model: active-high data, active-low carries; returns {carry_out_n, f}.
    function automatic logic [4:0] slice181(input logic m, input logic [3:0] s,
                                            input logic [3:0] a, input logic [3:0] b, input logic cn);
        logic [4:0] sum;
        logic [3:0] f;
        if (m) begin
            case (s)
                4'b0000: f = ~a;       4'b0001: f = ~(a | b); 4'b0010: f = ~a & b;  4'b0011: f = 4'h0;
                4'b0100: f = ~(a & b); 4'b0101: f = ~b;       4'b0110: f = a ^ b;   4'b0111: f = a & ~b;
                4'b1000: f = ~a | b;   4'b1001: f = ~(a ^ b); 4'b1010: f = b;       4'b1011: f = a & b;
                4'b1100: f = 4'hF;     4'b1101: f = a | ~b;   4'b1110: f = a | b;   default: f = a;
            endcase
            return {1'b1, f};
        end
        case (s)
            4'b1001: sum = {1'b0, a} + {1'b0, b} + {4'd0, ~cn};
            4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {4'd0, ~cn};
            default: sum = {1'b0, a} + {4'd0, ~cn};
        endcase
        return {~sum[4], sum[3:0]};
    endfunction

    always_comb begin
        {alu_carry_i, alu_f_i} = slice181(alu_mode_o, alu_select_o, alu_a_o, alu_b_o, alu_carry_o);
        alu_cmp_i = alu_f_i == 4'hF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One op: accept, scramble inputs during RUN, wait for done, check latency and pulse width.
    task automatic do_op(input logic m, input logic [3:0] s, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = m; select_i = s; a_i = a; b_i = b; carry_i = c;
        @(posedge clk_i); #1;
        start_i = 1'b0; mode_i = ~m; select_i = ~s; a_i = ~a ^ 16'h5A5A; b_i = ~b; carry_i = ~c;
        lat = 1;
        nibc = 4'd0;
        while (!done_o && lat < 20) begin
            if (lat <= 4) nibc[lat-1] = alu_carry_o;
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", lat, 5);
        @(posedge clk_i); #1;
        check("done_pulse", {busy_o, done_o}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_outs", {busy_o, done_o, carry_o, equal_o, result_o}, 20'h0);
        check("rst_alu", {alu_mode_o, alu_select_o, alu_a_o, alu_b_o, alu_carry_o}, 14'h0001);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        do_op(1'b0, 4'b1001, 16'h00FF, 16'h0001, 1'b0);
        check("add_res", result_o, 16'h0100);
        check("add_carry", carry_o, 1'b0);
        check("add_chain", nibc, 4'b1001);
        check("add_eq", equal_o, 1'b0);

        do_op(1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b0);
        check("ovf_res", result_o, 16'h0000);
        check("ovf_carry", carry_o, 1'b1);

        do_op(1'b0, 4'b0110, 16'h1234, 16'h1234, 1'b0);
        check("cmp_res", result_o, 16'hFFFF);
        check("cmp_flags", {equal_o, carry_o}, 2'b10);

        do_op(1'b0, 4'b0110, 16'h1234, 16'h1234, 1'b1);
        check("sub_res", result_o, 16'h0000);
        check("sub_flags", {equal_o, carry_o}, 2'b01);

        do_op(1'b1, 4'b1011, 16'hF0F0, 16'hFF00, 1'b0);
        check("and_res", result_o, 16'hF000);
        do_op(1'b1, 4'b1001, 16'hF0F0, 16'hFF00, 1'b0);
        check("xnor_res", result_o, 16'hF00F);

        // start held high: accepts on every DONE cycle, busy drops only there
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = 1'b0; select_i = 4'b1001; a_i = 16'h1111; b_i = 16'h2222; carry_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i); #1;
            check("bb_done", done_o, (i % 5) == 4);
            check("bb_busy", busy_o, (i % 5) != 4);
            if (done_o) begin
                dones++;
                check("bb_res", result_o, 16'h3333);
            end
        end
        start_i = 1'b0;
        check("bb_count", dones, 3);
        @(posedge clk_i); #1;
        check("bb_idle", {busy_o, done_o}, 2'b00);

        // reset during nibble 2 of an add
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = 1'b0; select_i = 4'b1001; a_i = 16'h00FF; b_i = 16'h0001; carry_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("mid_busy", busy_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_outs", {busy_o, done_o, carry_o, equal_o, result_o}, 20'h0);
        check("arst_alu", {alu_mode_o, alu_select_o, alu_a_o, alu_b_o, alu_carry_o}, 14'h0001);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) dones++;
        end
        check("no_done", dones, 0);

        do_op(1'b0, 4'b1001, 16'h0FFF, 16'h0001, 1'b1);
        check("post_rst_res", result_o, 16'h1001);
        check("post_rst_carry", carry_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
